mant_mul_seq: RTL and testbench
===============================

Name: mant_mul_seq

Overview:
- Sequential radix-2 shift-add mantissa multiplier for the FP unit.
- Computes the full double-width product of two unsigned mantissas, hidden bit included.
- Has a square mode, so squaring is the inverse operation of the mantissa square root and is used by FP_Sqrt result checking and FMUL.
- Uses the same start/stall handshake as the other iterative FP sub-units.

Parameters:
- W, 24: operand width in bits (24 = single-precision mantissa with hidden bit).
- CW, 5: iteration counter width; must satisfy 2^CW > W.

Ports:
- in_Clk  input  1  clock; all state updates on the rising edge.
- in_Rst  input  1  synchronous, active-high reset.
- in_start  input  1  starts an operation when the block is not busy.
- in_sq  input  1  square mode: in_b is ignored and in_a is used as both operands.
- in_a  input  W  multiplicand (unsigned).
- in_b  input  W  multiplier (unsigned).
- out_stall  output  1  high while an operation is in progress.
- out_done  output  1  one-cycle pulse when out_product becomes valid.
- out_product  output  2W  unsigned product in_a*in_b (or in_a*in_a); held until the next accepted start.

Behaviour:
- Reset: in_Rst sampled high on a rising edge.
  - Forces state IDLE, out_stall=0, out_done=0, out_product=0, counter=0.
  - Clears internal registers.
  - Reset mid-operation aborts the operation; no out_done is produced.
- States:
  - IDLE: out_stall=0, out_done=0. in_start=1 -> latch operands, clear accumulator, counter=0, go to BUSY.
  - BUSY: out_stall=1, out_done=0. One iteration per cycle:
    - if multiplier LSB=1, accumulator += multiplicand (shifted to its current position);
    - shift the multiplier right by 1;
    - counter += 1.
    - After the W-th iteration (counter==W-1 at the edge), go to DONE.
  - DONE: out_stall=0, out_done=1 for exactly this cycle.
    - out_product = final accumulator.
    - in_start=1 in DONE is accepted exactly as in IDLE (back-to-back go to BUSY); otherwise go to IDLE.
- Operand latching:
  - Operands are latched on the accepting edge only.
  - Changes to in_a, in_b or in_sq during BUSY have no effect.
- in_start while BUSY is ignored (no queueing).
- Latency:
  - in_start accepted at edge k -> out_stall=1 from cycle k+1 through k+W.
  - out_done=1 in cycle k+W+1.
  - Throughput: one result per W+1 cycles.
- Arithmetic:
  - The accumulator is 2W bits wide and cannot overflow, since (2^W-1)^2 < 2^2W.
  - Operands and product are unsigned; there is no rounding and no normalisation.
  - The caller handles normalisation (product MSB at bit 2W-1 or 2W-2).
- out_product:
  - Updates only on entry to DONE.
  - Keeps the previous result during BUSY and IDLE.
  - Resets to 0.
- Zero operand: still takes the full W iterations; result 0. Latency is fixed and data-independent.

Test Plan:
- Reset, then in_a=0x800000, in_b=0x800000, in_sq=0, start -> out_stall high for exactly 24 cycles, out_done pulse at cycle 25, out_product=0x400000000000.
- in_a=0xFFFFFF, in_b=0xFFFFFF -> out_product=0xFFFFFE000001 (max operands, no overflow).
- in_sq=1, in_a=0xC00000, in_b=0x123456 -> out_product=0x900000000000 (in_b ignored).
- in_a=0x000000, in_b=0xABCDEF -> out_product=0 after the same 25-cycle latency. Then assert in_start with new operands during BUSY -> ignored, and out_product keeps its prior value until DONE.
- Back-to-back: assert in_start in the DONE cycle with in_a=0x000003, in_b=0x000005 -> out_stall high on the next cycle with no IDLE gap; out_product=0x00000000000F.
- Assert in_Rst at iteration 10 of an operation -> next cycle out_stall=0, out_done=0, out_product=0, and no out_done pulse follows. A subsequent start completes normally.

Source files
------------

// File: rtl/mant_mul_seq.sv
// Sequential radix-2 shift-add mantissa multiplier.
// Produces the full 2W-bit unsigned product of two W-bit mantissas in W
// iterations, with a fixed latency that does not depend on the data.
// Square mode uses in_a as both operands.
//
// Ports:
//   in_Clk       clock, rising edge
//   in_Rst       synchronous active-high reset
//   in_start     start request, accepted in IDLE or DONE
//   in_sq        square mode (in_b ignored)
//   in_a, in_b   W-bit unsigned operands, latched on the accepting edge
//   out_stall    high while iterating
//   out_done     one-cycle pulse when out_product is updated
//   out_product  2W-bit product, held until the next result
module mant_mul_seq #(
   parameter int unsigned W  = 24,
   parameter int unsigned CW = 5
) (
   input  logic            in_Clk,
   input  logic            in_Rst,
   input  logic            in_start,
   input  logic            in_sq,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   output logic            out_stall,
   output logic            out_done,
   output logic [2*W-1:0]  out_product
);

   localparam int unsigned PW = 2 * W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q,   state_d;
   logic [PW-1:0]   mcand_q,   mcand_d;
   logic [W-1:0]    mplier_q,  mplier_d;
   logic [PW-1:0]   acc_q,     acc_d;
   logic [CW-1:0]   cnt_q,     cnt_d;
   logic [PW-1:0]   product_q, product_d;
   logic            stall_q,   stall_d;
   logic            done_q,    done_d;

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // DONE accepts a start exactly like IDLE, giving back-to-back issue.
            if (in_start) begin
               mcand_d  = PW'(in_a);
               mplier_d = in_sq ? in_a : in_b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = S_BUSY;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_BUSY: begin
            // Multiplicand moves left as multiplier bits are consumed from the LSB.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               product_d = acc_d;
               state_d   = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      stall_d = (state_d == S_BUSY);
      done_d  = (state_d == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge in_Clk) begin
      if (in_Rst) begin
         state_q   <= S_IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         stall_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         stall_q   <= stall_d;
         done_q    <= done_d;
      end
   end

   assign out_stall   = stall_q;
   assign out_done    = done_q;
   assign out_product = product_q;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq: expected products are queued when an
// operation is issued and compared when out_done pulses.
module tb_mant_mul_seq;

   localparam int unsigned W  = 24;
   localparam int unsigned CW = 5;
   localparam int unsigned PW = 2 * W;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           sq;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           stall;
   logic           done;
   logic [PW-1:0]  product;

   logic [PW-1:0]  sb[$];
   int             n_cmp = 0;
   int             n_err = 0;

   mant_mul_seq #(.W(W), .CW(CW)) dut (
      .in_Clk      (clk),
      .in_Rst      (rst),
      .in_start    (start),
      .in_sq       (sq),
      .in_a        (a),
      .in_b        (b),
      .out_stall   (stall),
      .out_done    (done),
      .out_product (product)
   );

   always #5 clk = ~clk;

   // Drive a start for one edge (caller is at a negedge) and queue the expected product.
   task automatic issue_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isq);
      logic [W-1:0] eb;
      eb    = isq ? ia : ib;
      a     = ia;
      b     = ib;
      sq    = isq;
      start = 1'b1;
      sb.push_back(PW'(ia) * PW'(eb));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for out_done; reports cycles waited, stall cycles seen and whether product moved early.
   task automatic wait_done(output int cyc, output int stl, output bit hit, output bit changed);
      logic [PW-1:0] p0;
      p0 = product;
      cyc = 0; stl = 0; hit = 1'b0; changed = 1'b0;
      while (cyc < 200) begin
         if (done) begin
            hit = 1'b1;
            break;
         end
         if (stall) stl++;
         if (product !== p0) changed = 1'b1;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic pop_exp(output logic [PW-1:0] e);
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sq = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
      n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product got=%h exp=0", product); end
   endtask

   task automatic test_basic();
      int cyc, stl; bit hit, ch; logic [PW-1:0] e;
      issue_op(24'h800000, 24'h800000, 1'b0);
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL basic_stall_rise got=%b exp=1", stall); end
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (!hit) begin n_err++; $display("FAIL basic_timeout got=no_done exp=done"); end
      n_cmp++; if (cyc !== W) begin n_err++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, W); end
      n_cmp++; if (stl !== W) begin n_err++; $display("FAIL basic_stall_cycles got=%0d exp=%0d", stl, W); end
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL basic_stall_in_done got=%b exp=0", stall); end
      n_cmp++; if (product !== e) begin n_err++; $display("FAIL basic_product got=%h exp=%h", product, e); end
      n_cmp++; if (product !== 48'h400000000000) begin n_err++; $display("FAIL basic_const got=%h exp=400000000000", product); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
      n_cmp++; if (product !== e) begin n_err++; $display("FAIL basic_hold got=%h exp=%h", product, e); end
   endtask

   task automatic test_max();
      int cyc, stl; bit hit, ch; logic [PW-1:0] e;
      issue_op(24'hFFFFFF, 24'hFFFFFF, 1'b0);
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (!hit || product !== e) begin n_err++; $display("FAIL max_product got=%h exp=%h", product, e); end
      n_cmp++; if (product !== 48'hFFFFFE000001) begin n_err++; $display("FAIL max_const got=%h exp=fffffe000001", product); end
      @(negedge clk);
   endtask

   task automatic test_square();
      int cyc, stl; bit hit, ch; logic [PW-1:0] e;
      issue_op(24'hC00000, 24'h123456, 1'b1);
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (!hit || product !== e) begin n_err++; $display("FAIL square_product got=%h exp=%h", product, e); end
      n_cmp++; if (product !== 48'h900000000000) begin n_err++; $display("FAIL square_const got=%h exp=900000000000", product); end
      @(negedge clk);
   endtask

   task automatic test_zero_ignore();
      int cyc, stl; bit hit, ch; logic [PW-1:0] e, prev;
      prev = product;
      issue_op(24'h000000, 24'hABCDEF, 1'b0);
      // Start request and operand changes while busy must have no effect.
      a = 24'hFFFFFF; b = 24'hFFFFFF; sq = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL zero_busy_stall got=%b exp=1", stall); end
      n_cmp++; if (product !== prev) begin n_err++; $display("FAIL zero_busy_hold got=%h exp=%h", product, prev); end
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (ch) begin n_err++; $display("FAIL zero_held_until_done got=changed exp=held"); end
      n_cmp++; if (!hit || cyc + 1 !== W) begin n_err++; $display("FAIL zero_latency got=%0d exp=%0d", cyc + 1, W); end
      n_cmp++; if (product !== e || product !== '0) begin n_err++; $display("FAIL zero_product got=%h exp=%h", product, e); end
      @(negedge clk);
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL zero_no_queue got=%b exp=0", stall); end
   endtask

   task automatic test_back_to_back();
      int cyc, stl; bit hit, ch; logic [PW-1:0] e;
      issue_op(24'h000007, 24'h000009, 1'b0);
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (!hit || product !== e) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", product, e); end
      issue_op(24'h000003, 24'h000005, 1'b0);
      n_cmp++; if (stall !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_no_gap got=stall%b_done%b exp=stall1_done0", stall, done); end
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (!hit || cyc !== W) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc, W); end
      n_cmp++; if (product !== e || product !== 48'h00000000000F) begin n_err++; $display("FAIL b2b_product got=%h exp=%h", product, e); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc, stl; bit hit, ch, seen; logic [PW-1:0] e;
      issue_op(24'h123456, 24'h654321, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(sb.pop_back());
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", done); end
      n_cmp++; if (product !== '0) begin n_err++; $display("FAIL rstmid_product got=%h exp=0", product); end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done || stall) seen = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (seen) begin n_err++; $display("FAIL rstmid_aborted got=activity exp=none"); end
      issue_op(24'hABCDEF, 24'h13579B, 1'b0);
      wait_done(cyc, stl, hit, ch);
      pop_exp(e);
      n_cmp++; if (!hit || cyc !== W || product !== e) begin n_err++; $display("FAIL rstmid_after got=%h exp=%h", product, e); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int cyc, stl; bit hit, ch; logic [PW-1:0] e;
      for (int i = 0; i < 6; i++) begin
         issue_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         wait_done(cyc, stl, hit, ch);
         pop_exp(e);
         n_cmp++; if (!hit || stl !== W || product !== e) begin n_err++; $display("FAIL random_%0d got=%h exp=%h", i, product, e); end
      end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_max();
      test_square();
      test_zero_ignore();
      test_back_to_back();
      test_reset_mid();
      test_random();
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
